e_mdu: RTL

- Multiply/divide unit for the E stage of the 5-stage pipeline; sits beside the ALU.
- Operands come from the E-stage forwarding muxes (rs/rt after forwarding).
- Owns the HI/LO registers.
- Executes mult/multu/div/divu with a fixed multi-cycle latency, services mthi/mtlo writes, and supplies mfhi/mflo read data into the E/M pipeline register.
- Exposes start/busy so the stall controller can freeze the D stage on MDU-dependent instructions.

---
 rtl/e_mdu_pkg.sv | 30 +++
 rtl/e_mdu.sv | 126 ++++++++++++
 2 files changed

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the E-stage multiply/divide unit.
// Holds the MDU operation codes (same values as the MDU_* codes in const.v)
// and small decode helpers used by e_mdu and its testbench.
package e_mdu_pkg;

    localparam int MDU_W = 32;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    // True for the four ops that start a multi-cycle computation.
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit for the E stage. Owns HI/LO.
//   clk, reset : pipeline clock, synchronous active-high reset
//   mdu_op     : MDU operation code (e_mdu_pkg::mdu_op_e values)
//   start      : E-stage request to begin mult/multu/div/divu
//   data1/2    : forwarded rs / rt operands
//   busy       : high for exactly MULT_CYCLES / DIV_CYCLES after a start
//   mdu_out    : HI on MFHI, LO on MFLO, else 0 (combinational)
//   hi, lo     : current architectural HI/LO
// Handshake: an operation is taken on a posedge with start=1 and busy=0;
// start while busy=1 is dropped. The result is computed at accept time and
// held in hi_tmp/lo_tmp; it lands in HI/LO on the edge that busy falls.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   hi_q, lo_q, hi_tmp, lo_tmp;
    logic          commit_en;   // pending result may be written (not div-by-zero)

    // 64-bit operand views; signed division in 64 bits makes
    // 0x80000000 / -1 come out as quotient 0x80000000, remainder 0.
    logic signed [63:0] s_a, s_b, s_b_safe;
    logic        [63:0] u_a, u_b, u_b_safe;
    logic signed [63:0] prod_s, quot_s, rem_s;
    logic        [63:0] prod_u, quot_u, rem_u;
    logic               div_zero;

    logic [31:0]   res_hi, res_lo;
    logic          res_wr;
    logic [CW-1:0] res_cnt;
    logic          accept;

    assign s_a      = {{32{data1[31]}}, data1};
    assign s_b      = {{32{data2[31]}}, data2};
    assign u_a      = {32'd0, data1};
    assign u_b      = {32'd0, data2};
    assign div_zero = (data2 == 32'd0);
    // Divisor forced to 1 on zero so the dividers never see 0; result is discarded anyway.
    assign s_b_safe = div_zero ? 64'sd1 : s_b;
    assign u_b_safe = div_zero ? 64'd1  : u_b;

    assign prod_s = s_a * s_b;
    assign quot_s = s_a / s_b_safe;
    assign rem_s  = s_a % s_b_safe;
    assign prod_u = u_a * u_b;
    assign quot_u = u_a / u_b_safe;
    assign rem_u  = u_a % u_b_safe;

    always_comb begin
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_wr  = 1'b1;
        res_cnt = CW'(MULT_CYCLES);
        case (mdu_op)
            MDU_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            MDU_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            MDU_DIV:   begin res_hi = rem_s[31:0];   res_lo = quot_s[31:0]; end
            MDU_DIVU:  begin res_hi = rem_u[31:0];   res_lo = quot_u[31:0]; end
            default:   ;
        endcase
        if (is_div_op(mdu_op)) begin
            res_cnt = CW'(DIV_CYCLES);
            res_wr  = !div_zero;
        end
    end

    assign busy   = (cnt != '0);
    assign accept = start && !busy && is_arith_op(mdu_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_tmp    <= 32'd0;
            lo_tmp    <= 32'd0;
            commit_en <= 1'b0;
        end else if (accept) begin
            cnt       <= res_cnt;
            hi_tmp    <= res_hi;
            lo_tmp    <= res_lo;
            commit_en <= res_wr;
        end else if (busy) begin
            if (cnt == CW'(1)) begin
                cnt       <= '0;
                commit_en <= 1'b0;
                if (commit_en) begin
                    hi_q <= hi_tmp;
                    lo_q <= lo_tmp;
                end
            end else begin
                cnt <= cnt - CW'(1);
            end
        end else if (!start) begin
            if (mdu_op == MDU_MTHI) hi_q <= data1;
            if (mdu_op == MDU_MTLO) lo_q <= data1;
        end
    end

    always_comb begin
        mdu_out = 32'd0;
        if (mdu_op == MDU_MFHI) mdu_out = hi_q;
        if (mdu_op == MDU_MFLO) mdu_out = lo_q;
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
